// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - collects ADC samples into frames and launches them into an FFT with a watchdog.
// Optional overrun counter is built only when FFT_SEQ_OVERRUN_CNT_EN is defined.
module fft_frame_sequencer #(
  parameter int N_POINTS    = 8,
  parameter int SAMPLE_W    = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         adc_clk,
  input  logic                         reset,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         sample_valid,
  input  logic                         fft_done,
  output logic                         fft_start,
  output logic [N_POINTS*SAMPLE_W-1:0] fft_frame,
  output logic                         busy,
  output logic                         frame_pending,
  output logic [15:0]                  overrun_cnt,
  output logic                         timeout_err
);

  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t                         state;
  state_t                         next_state;
  logic [IDX_W-1:0]               idx;
  logic [WD_W-1:0]                wd;
  logic [SAMPLE_W-1:0]            fill_buf [N_POINTS];
  logic [N_POINTS*SAMPLE_W-1:0]   pending_buf;
  logic [N_POINTS*SAMPLE_W-1:0]   complete_frame;
  logic                           frame_done;
  logic                           consume;
  logic                           timeout_hit;

  assign frame_done = sample_valid && (idx == IDX_LAST);

  // The last sample bypasses the fill buffer so the frame is complete in the same cycle.
  always_comb begin
    complete_frame = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      if (k == N_POINTS - 1)
        complete_frame[k*SAMPLE_W +: SAMPLE_W] = sample_in;
      else
        complete_frame[k*SAMPLE_W +: SAMPLE_W] = fill_buf[k];
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!reset && sample_valid)
      fill_buf[idx] <= sample_in;
  end

  always_ff @(posedge adc_clk) begin
    if (reset)
      idx <= '0;
    else if (sample_valid)
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  always_comb begin
    next_state  = state;
    fft_start   = 1'b0;
    busy        = 1'b0;
    consume     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (frame_pending) begin
          consume    = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        fft_start  = 1'b1;
        next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (fft_done) begin
          next_state = IDLE;
        end else if (wd == WD_LAST) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state         <= IDLE;
      wd            <= '0;
      fft_frame     <= '0;
      frame_pending <= 1'b0;
      pending_buf   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == BUSY && next_state == BUSY)
        wd <= wd + 1'b1;
      else
        wd <= '0;
      if (consume)
        fft_frame <= pending_buf;
      // A newly completed frame always wins over the one being consumed or overwritten.
      if (frame_done) begin
        pending_buf   <= complete_frame;
        frame_pending <= 1'b1;
      end else if (consume) begin
        frame_pending <= 1'b0;
      end
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end

`ifdef FFT_SEQ_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge adc_clk) begin
    if (reset)
      overrun_q <= '0;
    else if (frame_done && frame_pending && !consume && overrun_q != 16'hFFFF)
      overrun_q <= overrun_q + 16'd1;
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 16'd0;
`endif

endmodule
